// File: rtl/life_gen_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
package life_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    LOAD,
    PAUSED,
    WAIT_TICK,
    WAIT_VB,
    UPDATE,
    CHECK
  } state_t;

  // Ticks per generation at the fastest speed; each lower speed doubles it.
  localparam int INTERVAL_BASE    = 16;
  // Length of the seed-load strobe in clock cycles.
  localparam int LOAD_CYCLES      = 2;
  // 1 ms base tick at 100 MHz.
  localparam int TICK_DIV_DEFAULT = 100000;
  // Interval counter width; holds the slowest limit of 2047.
  localparam int IVAL_W           = 12;
  localparam int LOAD_CNT_W       = $clog2(LOAD_CYCLES + 1);

  // Last count of an interval: (16 << (7 - speed)) - 1.
  function automatic logic [IVAL_W-1:0] interval_limit(input logic [2:0] speed);
    int unsigned shift;
    shift = 32'(3'd7 - speed);
    return IVAL_W'((INTERVAL_BASE << shift) - 1);
  endfunction

endpackage

// File: rtl/life_gen_ctrl_if.sv
// Signal bundle between the sequencer, the buttons, the VGA timing and the cell array.
//
// Handshake: there is no valid/ready pair here. run_toggle, step and reload are
// single-cycle pulses sampled on the rising edge of clk; the sequencer never
// stalls its source, and a pulse the current state cannot use is dropped.
// vblank, alive_any and speed_sel are levels sampled every cycle.
interface life_gen_ctrl_if #(
  parameter int GEN_W = 16
);
  logic              run_toggle;
  logic              step;
  logic              reload;
  logic [2:0]        speed_sel;
  logic              vblank;
  logic              alive_any;
  logic              cell_en;
  logic              array_rst_n;
  logic              running;
  logic              extinct;
  logic [GEN_W-1:0]  gen_count;
  life_pkg::state_t  state;

  // Sequencer side
  modport slave (
    input  run_toggle, step, reload, speed_sel, vblank, alive_any,
    output cell_en, array_rst_n, running, extinct, gen_count, state
  );

  // Stimulus / board side
  modport master (
    output run_toggle, step, reload, speed_sel, vblank, alive_any,
    input  cell_en, array_rst_n, running, extinct, gen_count, state
  );
endinterface

// File: rtl/life_gen_ctrl_tick_gen.sv
// Base-tick prescaler plus speed-scaled interval counter; pulses done when an
// interval of generation time has elapsed.
module life_tick_gen
  import life_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [2:0] speed_sel,
  input  logic       clear,
  output logic       done
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [IVAL_W-1:0] ival_cnt;
  logic [IVAL_W-1:0] limit;
  logic              at_limit;

  assign tick     = (pre_cnt == PRE_LAST);
  assign limit    = interval_limit(speed_sel);
  // ">=" so a speed change that leaves the count past the new limit finishes
  // the interval on the very next tick.
  assign at_limit = (ival_cnt >= limit);
  assign done     = tick && at_limit;

  // Free-running prescaler; only Rst restarts its phase.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Interval counter: counts ticks, restarts on completion or on request.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ival_cnt <= '0;
    end else if (clear || done) begin
      ival_cnt <= '0;
    end else if (tick) begin
      ival_cnt <= ival_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer: run/pause/step/reload control, vblank-aligned update
// strobe, saturating generation counter and extinction halt.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int GEN_W    = 16
) (
  input  logic           clk,
  input  logic           Rst,
  life_gen_ctrl_if.slave bus
);

  state_t                state;
  state_t                state_next;
  logic [LOAD_CNT_W-1:0] load_cnt;
  logic [LOAD_CNT_W-1:0] load_next;
  logic                  running;
  logic                  run_next;
  logic                  extinct;
  logic                  ext_next;
  logic [GEN_W-1:0]      gen_count;
  logic [GEN_W-1:0]      gen_next;
  logic                  cell_en_q;
  logic                  arst_q;
  logic                  interval_done;
  logic                  ival_clear;

  // The interval restarts whenever WAIT_TICK is entered, so each generation
  // in run mode waits at least one full interval.
  assign ival_clear = (state != WAIT_TICK) && (state_next == WAIT_TICK);

  life_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .Rst       (Rst),
    .speed_sel (bus.speed_sel),
    .clear     (ival_clear),
    .done      (interval_done)
  );

  // Next state and next values of every sequencer register.
  always_comb begin
    state_next = state;
    load_next  = load_cnt;
    run_next   = running;
    ext_next   = extinct;
    gen_next   = gen_count;

    if (bus.reload) begin
      // Reload beats every other command, and restarts a strobe in progress.
      state_next = LOAD;
      load_next  = '0;
      run_next   = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_cnt == LOAD_CNT_W'(LOAD_CYCLES - 1)) begin
            state_next = PAUSED;
          end else begin
            load_next = load_cnt + 1'b1;
          end
        end
        PAUSED: begin
          // An extinct array stays frozen until the seed is reloaded.
          if (!extinct) begin
            if (bus.run_toggle) begin
              run_next   = 1'b1;
              state_next = WAIT_TICK;
            end else if (bus.step) begin
              state_next = WAIT_VB;
            end
          end
        end
        WAIT_TICK: begin
          if (bus.run_toggle) begin
            run_next   = 1'b0;
            state_next = PAUSED;
          end else if (interval_done) begin
            state_next = WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (bus.run_toggle) begin
            run_next   = 1'b0;
            state_next = PAUSED;
          end else if (bus.vblank) begin
            state_next = UPDATE;
          end
        end
        UPDATE: begin
          // A pause here lets the generation finish; CHECK then sees
          // running low and parks in PAUSED.
          if (bus.run_toggle) begin
            run_next = 1'b0;
          end
          state_next = CHECK;
        end
        CHECK: begin
          if (!bus.alive_any) begin
            ext_next   = 1'b1;
            run_next   = 1'b0;
            state_next = PAUSED;
          end else begin
            if (gen_count != '1) begin
              gen_next = gen_count + 1'b1;
            end
            if (running && !bus.run_toggle) begin
              state_next = WAIT_TICK;
            end else begin
              run_next   = 1'b0;
              state_next = PAUSED;
            end
          end
        end
        default: begin
          state_next = LOAD;
          load_next  = '0;
          run_next   = 1'b0;
        end
      endcase
    end

    // Loading a seed starts a fresh history.
    if (state_next == LOAD) begin
      gen_next = '0;
      ext_next = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and output registers, all loaded from next-cycle values so the
  // strobes line up with the state they belong to.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      load_cnt  <= '0;
      running   <= 1'b0;
      extinct   <= 1'b0;
      gen_count <= '0;
      cell_en_q <= 1'b0;
      arst_q    <= 1'b0;
    end else begin
      load_cnt  <= load_next;
      running   <= run_next;
      extinct   <= ext_next;
      gen_count <= gen_next;
      cell_en_q <= (state_next == UPDATE);
      arst_q    <= (state_next != LOAD);
    end
  end

  assign bus.cell_en     = cell_en_q;
  assign bus.array_rst_n = arst_q;
  assign bus.running     = running;
  assign bus.extinct     = extinct;
  assign bus.gen_count   = gen_count;
  assign bus.state       = state;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: command vector table, hand-written corner
// sequences and randomized stepping/running against a behavioural model.
module tb_life_gen_ctrl;
  import life_pkg::*;

  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Rst = 1'b0;
  always #5 clk = ~clk;

  life_gen_ctrl_if #(.GEN_W(16)) bus ();
  life_gen_ctrl_if #(.GEN_W(2))  bus2 ();

  life_gen_ctrl #(.TICK_DIV(TD), .GEN_W(16)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Narrow twin sharing the same inputs, used to see the counter saturate.
  life_gen_ctrl #(.TICK_DIV(TD), .GEN_W(2)) dut_sat (
    .clk (clk),
    .Rst (Rst),
    .bus (bus2)
  );

  assign bus2.run_toggle = bus.run_toggle;
  assign bus2.step       = bus.step;
  assign bus2.reload     = bus.reload;
  assign bus2.speed_sel  = bus.speed_sel;
  assign bus2.vblank     = bus.vblank;
  assign bus2.alive_any  = bus.alive_any;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Cycles in one generation interval at a given speed.
  function automatic int ival_cycles(input int speed);
    return (INTERVAL_BASE << (7 - speed)) * TD;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    bus.run_toggle = 1'b1;
    step_clk();
    bus.run_toggle = 1'b0;
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    step_clk();
    bus.reload = 1'b0;
    step_clk();
    step_clk();
  endtask

  // Counts consecutive low samples of array_rst_n from the current one.
  task automatic measure_load(input string name);
    int n;
    n = 0;
    while (bus.array_rst_n == 1'b0 && n < 10) begin
      n++;
      step_clk();
    end
    chk(name, 64'(n), 64'd2);
  endtask

  task automatic wait_cell(input string name, input int max_cyc);
    int w;
    w = 0;
    while (bus.cell_en !== 1'b1 && w < max_cyc) begin
      step_clk();
      w++;
    end
    chk(name, bus.cell_en, 1'b1);
  endtask

  task automatic count_cells(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.cell_en === 1'b1) seen++;
      step_clk();
    end
  endtask

  // ---------------- command vector table ----------------
  typedef struct {
    string name;
    logic  rt;
    logic  st;
    logic  rl;
    logic  vb;
    logic  e_run;
    logic  e_arst;
    logic  e_cell;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rt, input logic st,
                              input logic rl, input logic vb, input logic e_run,
                              input logic e_arst, input logic e_cell);
    vec_t v;
    v.name = name; v.rt = rt; v.st = st; v.rl = rl; v.vb = vb;
    v.e_run = e_run; v.e_arst = e_arst; v.e_cell = e_cell;
    return v;
  endfunction

  vec_t vecs[7];

  // ---------------- test sequence ----------------
  initial begin
    int seen;
    int last;
    int pulses;
    int k;
    int exp_gen;
    int spd;
    logic vb;
    logic got;

    vecs[0] = mk("v_idle",      0, 0, 0, 1, 0, 1, 0);
    vecs[1] = mk("v_step_vb",   0, 1, 0, 1, 0, 1, 1);
    vecs[2] = mk("v_step_novb", 0, 1, 0, 0, 0, 1, 0);
    vecs[3] = mk("v_run",       1, 0, 0, 1, 1, 1, 0);
    vecs[4] = mk("v_reload",    0, 0, 1, 1, 0, 0, 0);
    vecs[5] = mk("v_rl_run",    1, 0, 1, 1, 0, 0, 0);
    vecs[6] = mk("v_rl_step",   0, 1, 1, 1, 0, 0, 0);

    bus.run_toggle = 1'b0;
    bus.step       = 1'b0;
    bus.reload     = 1'b0;
    bus.speed_sel  = 3'd7;
    bus.vblank     = 1'b0;
    bus.alive_any  = 1'b1;

    // Reset values and the post-reset load strobe
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cell_en", bus.cell_en, 1'b0);
    chk("rst_arst_n", bus.array_rst_n, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_extinct", bus.extinct, 1'b0);
    chk("rst_gen", bus.gen_count, 16'd0);
    Rst = 1'b1;
    measure_load("rst_load_len");
    chk("rst_paused", bus.state, PAUSED);
    chk("rst_gen_after", bus.gen_count, 16'd0);
    chk("rst_run_after", bus.running, 1'b0);

    // Table: one command cycle from PAUSED
    for (int i = 0; i < 7; i++) begin
      do_reload();
      bus.vblank     = vecs[i].vb;
      bus.run_toggle = vecs[i].rt;
      bus.step       = vecs[i].st;
      bus.reload     = vecs[i].rl;
      step_clk();
      bus.run_toggle = 1'b0;
      bus.step       = 1'b0;
      bus.reload     = 1'b0;
      chk({vecs[i].name, "_run"}, bus.running, vecs[i].e_run);
      chk({vecs[i].name, "_arst"}, bus.array_rst_n, vecs[i].e_arst);
      step_clk();
      chk({vecs[i].name, "_cell"}, bus.cell_en, vecs[i].e_cell);
    end

    // Single step with vblank high: strobe latency and counter timing
    do_reload();
    bus.vblank = 1'b1;
    bus.step   = 1'b1;
    step_clk();
    bus.step = 1'b0;
    chk("step_cell_early", bus.cell_en, 1'b0);
    step_clk();
    chk("step_cell", bus.cell_en, 1'b1);
    step_clk();
    chk("step_cell_once", bus.cell_en, 1'b0);
    chk("step_gen_pre", bus.gen_count, 16'd0);
    step_clk();
    chk("step_gen", bus.gen_count, 16'd1);
    chk("step_paused", bus.state, PAUSED);
    chk("step_running", bus.running, 1'b0);

    // Run at speed 7 with vblank held: spacing and count of five generations
    do_reload();
    bus.speed_sel = 3'd7;
    bus.vblank    = 1'b1;
    pulse_run();
    chk("run_running", bus.running, 1'b1);
    last = -1;
    pulses = 0;
    for (int c = 0; c < 1000 && pulses < 5; c++) begin
      if (bus.cell_en === 1'b1) begin
        if (last >= 0) chk_range("run_spacing", c - last, ival_cycles(7), ival_cycles(7) + 3);
        last = c;
        pulses++;
      end
      step_clk();
    end
    chk("run_pulses", 64'(pulses), 64'd5);
    step_clk();
    chk("run_gen5", bus.gen_count, 16'd5);
    pulse_run();
    step_clk();
    chk("run_paused", bus.running, 1'b0);

    // Run with vblank withheld long past interval completion
    do_reload();
    bus.vblank = 1'b0;
    pulse_run();
    count_cells(ival_cycles(7) + 500, seen);
    chk("vb_hold_no_cell", 64'(seen), 64'd0);
    bus.vblank = 1'b1;
    step_clk();
    chk("vb_rise_cell", bus.cell_en, 1'b1);
    count_cells(40, seen);
    chk("vb_rise_once", 64'(seen), 64'd1);
    chk("vb_rise_gen", bus.gen_count, 16'd1);

    // Extinction in run mode on the second generation
    do_reload();
    bus.vblank    = 1'b1;
    bus.alive_any = 1'b1;
    pulse_run();
    wait_cell("ext_first_cell", 200);
    step_clk();
    wait_cell("ext_second_cell", 200);
    bus.alive_any = 1'b0;
    step_clk();
    step_clk();
    chk("ext_extinct", bus.extinct, 1'b1);
    chk("ext_running", bus.running, 1'b0);
    chk("ext_gen_held", bus.gen_count, 16'd1);
    bus.step = 1'b1;
    step_clk();
    bus.step = 1'b0;
    count_cells(20, seen);
    chk("ext_step_ignored", 64'(seen), 64'd0);
    pulse_run();
    chk("ext_run_ignored", bus.running, 1'b0);
    chk("ext_still", bus.extinct, 1'b1);
    bus.alive_any = 1'b1;
    do_reload();
    chk("ext_cleared", bus.extinct, 1'b0);

    // Reload together with run_toggle during UPDATE
    do_reload();
    bus.vblank = 1'b1;
    pulse_run();
    wait_cell("rlu_first_cell", 200);
    step_clk();
    wait_cell("rlu_second_cell", 200);
    chk("rlu_gen_before", bus.gen_count, 16'd1);
    bus.reload     = 1'b1;
    bus.run_toggle = 1'b1;
    step_clk();
    bus.reload     = 1'b0;
    bus.run_toggle = 1'b0;
    chk("rlu_state_load", bus.state, LOAD);
    measure_load("rlu_load_len");
    chk("rlu_gen", bus.gen_count, 16'd0);
    chk("rlu_extinct", bus.extinct, 1'b0);
    chk("rlu_running", bus.running, 1'b0);
    count_cells(100, seen);
    chk("rlu_no_cell", 64'(seen), 64'd0);

    // Speed raised mid-interval past the new limit: completes on next tick
    do_reload();
    bus.speed_sel = 3'd0;
    bus.vblank    = 1'b1;
    pulse_run();
    count_cells(200, seen);
    chk("spd_slow_no_cell", 64'(seen), 64'd0);
    bus.speed_sel = 3'd7;
    k = 0;
    while (bus.cell_en !== 1'b1 && k < 50) begin
      step_clk();
      k++;
    end
    chk_range("spd_jump_latency", k, 1, TD + 2);

    // run_toggle while waiting for vblank abandons the generation
    do_reload();
    bus.vblank = 1'b0;
    pulse_run();
    repeat (ival_cycles(7) + 40) step_clk();
    pulse_run();
    chk("wvb_running", bus.running, 1'b0);
    bus.vblank = 1'b1;
    count_cells(20, seen);
    chk("wvb_no_cell", 64'(seen), 64'd0);
    chk("wvb_paused", bus.state, PAUSED);
    chk("wvb_gen", bus.gen_count, 16'd0);

    // Random stepping: cell_en follows the first vblank cycle after step
    do_reload();
    exp_q.delete();
    exp_gen = 0;
    bus.alive_any = 1'b1;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.reload = 1'b1;
        step_clk();
        bus.reload = 1'b0;
        measure_load("rnd_reload_len");
        exp_gen = 0;
        chk("rnd_reload_gen", bus.gen_count, 16'd0);
      end else begin
        repeat ($urandom_range(0, 3)) begin
          bus.vblank = 1'($urandom_range(0, 1));
          step_clk();
        end
        bus.step   = 1'b1;
        bus.vblank = 1'($urandom_range(0, 1));
        step_clk();
        bus.step = 1'b0;
        chk("rnd_no_early_cell", bus.cell_en, 1'b0);
        got = 1'b0;
        for (int j = 0; j < 60 && !got; j++) begin
          vb = (j >= 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
          bus.vblank = vb;
          step_clk();
          chk("rnd_step_cell", bus.cell_en, vb);
          got = vb;
        end
        exp_gen++;
        exp_q.push_back(16'(exp_gen));
        step_clk();
        step_clk();
        chk("rnd_gen", bus.gen_count, exp_q.pop_front());
        chk("rnd_gen_sat", bus2.gen_count, (exp_gen > 3) ? 2'd3 : 2'(exp_gen));
        chk("rnd_paused", bus.running, 1'b0);
      end
    end

    // Random running: every strobe follows vblank and honours the interval
    do_reload();
    spd = $urandom_range(6, 7);
    bus.speed_sel = 3'(spd);
    pulse_run();
    last = -1;
    pulses = 0;
    for (int c = 0; c < 1500; c++) begin
      vb = 1'($urandom_range(0, 1));
      bus.vblank = vb;
      step_clk();
      if (bus.cell_en === 1'b1) begin
        chk("rrun_vb_before_cell", vb, 1'b1);
        if (last >= 0) chk_range("rrun_spacing", c - last, ival_cycles(spd), 100000);
        last = c;
        pulses++;
      end
    end
    bus.vblank = 1'b0;
    pulse_run();
    count_cells(4, seen);
    chk("rrun_no_extra", 64'(seen), 64'd0);
    chk("rrun_gen", bus.gen_count, 16'(pulses));
    chk_range("rrun_pulses", pulses, 1, 1500 / ival_cycles(spd));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
